// File: rtl/crc16_t_if.sv
// Byte-stream bus for crc16_t: transfer-layer side (tx_lt_*) and
// downstream transmit side (tx_*), each with valid/ready handshake.
interface crc16_t_if;
    logic       tx_lt_sop;
    logic       tx_lt_eop;
    logic       tx_lt_valid;
    logic       tx_lt_ready;
    logic [7:0] tx_lt_data;
    logic       tx_sop;
    logic       tx_eop;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;

    modport slave (
        input  tx_lt_sop, tx_lt_eop, tx_lt_valid, tx_lt_data, tx_ready,
        output tx_lt_ready, tx_sop, tx_eop, tx_valid, tx_data
    );

    modport master (
        output tx_lt_sop, tx_lt_eop, tx_lt_valid, tx_lt_data, tx_ready,
        input  tx_lt_ready, tx_sop, tx_eop, tx_valid, tx_data
    );
endinterface

// File: rtl/crc16_t.sv
// Transmit DATA-phase CRC16 generator: forwards PID + payload through one
// output register and appends the inverted USB CRC16 (low byte first).
module crc16_t (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tx_data_on,
    output logic         tx_sop_en,
    output logic         tx_eop_en,
    crc16_t_if.slave     bus
);

    typedef enum logic [1:0] {IDLE, DATA, CRC_LO, CRC_HI} state_t;

    state_t      state, state_nxt;
    logic [15:0] crc, crc_nxt;
    logic        free, acc;
    logic        ld, ld_sop, ld_eop;
    logic [7:0]  ld_data;
    logic        out_valid, out_sop, out_eop;
    logic [7:0]  out_data;

    // Reflected CRC-16/USB, all 8 bits of a byte folded in one cycle.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
            else             r = r >> 1;
        end
        return r;
    endfunction

    assign free = !out_valid || bus.tx_ready;

    // rst_n gating keeps ready low while reset is held even though the
    // register is empty.
    assign bus.tx_lt_ready = rst_n && tx_data_on && free &&
                             (state == IDLE || state == DATA);
    assign acc = bus.tx_lt_valid && bus.tx_lt_ready;

    assign bus.tx_valid = out_valid;
    assign bus.tx_sop   = out_sop;
    assign bus.tx_eop   = out_eop;
    assign bus.tx_data  = out_data;
    assign tx_eop_en    = out_valid && bus.tx_ready && out_eop;

    always_comb begin
        state_nxt = state;
        crc_nxt   = crc;
        ld        = 1'b0;
        ld_sop    = 1'b0;
        ld_eop    = 1'b0;
        ld_data   = bus.tx_lt_data;
        tx_sop_en = 1'b0;
        case (state)
            IDLE, DATA: begin
                if (acc) begin
                    if (bus.tx_lt_sop) begin
                        // PID: forwarded but never part of the CRC
                        ld        = 1'b1;
                        ld_sop    = 1'b1;
                        crc_nxt   = 16'hFFFF;
                        tx_sop_en = 1'b1;
                        state_nxt = bus.tx_lt_eop ? CRC_LO : DATA;
                    end else if (state == DATA) begin
                        ld      = 1'b1;
                        crc_nxt = crc16_byte(crc, bus.tx_lt_data);
                        if (bus.tx_lt_eop) state_nxt = CRC_LO;
                    end
                end
            end
            CRC_LO: begin
                if (free) begin
                    ld        = 1'b1;
                    ld_data   = ~crc[7:0];
                    state_nxt = CRC_HI;
                end
            end
            CRC_HI: begin
                if (free) begin
                    ld        = 1'b1;
                    ld_data   = ~crc[15:8];
                    ld_eop    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            crc   <= 16'hFFFF;
        end else begin
            state <= state_nxt;
            crc   <= crc_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_data  <= 8'h00;
        end else if (ld) begin
            out_valid <= 1'b1;
            out_sop   <= ld_sop;
            out_eop   <= ld_eop;
            out_data  <= ld_data;
        end else if (free) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_crc16_t.sv
// Scoreboard bench for crc16_t: driver pushes expected downstream bytes from a
// packet-level model; a monitor pops and compares on each downstream transfer.
module tb_crc16_t;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx_data_on = 1'b0;
    logic tx_sop_en, tx_eop_en;

    crc16_t_if bus();

    crc16_t dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data_on (tx_data_on),
        .tx_sop_en  (tx_sop_en),
        .tx_eop_en  (tx_eop_en),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    logic [7:0] m_pay[$];
    logic m_in = 1'b0;
    int   exp_sop_cnt = 0, exp_eop_cnt = 0;
    int   sop_seen = 0, eop_seen = 0;
    logic rdy_mode = 1'b1;
    logic on_rand = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // USB CRC16 over a whole payload, message bits taken LSB first.
    function automatic logic [15:0] crc16_ref(input logic [7:0] pay[$]);
        logic [15:0] r = 16'hFFFF;
        foreach (pay[k])
            for (int b = 0; b < 8; b++)
                r = ((r[0] ^ pay[k][b]) != 1'b0) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return ~r;
    endfunction

    task automatic model_end();
        logic [15:0] c;
        c = crc16_ref(m_pay);
        exp_q.push_back('{d: c[7:0],  sop: 1'b0, eop: 1'b0});
        exp_q.push_back('{d: c[15:8], sop: 1'b0, eop: 1'b1});
        exp_eop_cnt++;
        m_in = 1'b0;
    endtask

    task automatic put(input logic [7:0] d, input logic s, input logic e);
        int t;
        if (s) begin
            exp_q.push_back('{d: d, sop: 1'b1, eop: 1'b0});
            exp_sop_cnt++;
            m_pay.delete();
            m_in = 1'b1;
            if (e) model_end();
        end else if (m_in) begin
            exp_q.push_back('{d: d, sop: 1'b0, eop: 1'b0});
            m_pay.push_back(d);
            if (e) model_end();
        end
        bus.tx_lt_data  = d;
        bus.tx_lt_sop   = s;
        bus.tx_lt_eop   = e;
        bus.tx_lt_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (bus.tx_lt_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            t++;
            if (t > 500) begin
                tests++; fails++;
                $display("FAIL accept_timeout: byte %0h never accepted", d);
                break;
            end
        end
        bus.tx_lt_valid = 1'b0;
    endtask

    task automatic put_normal();
        logic [7:0] s9[9];
        s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        put(8'hC3, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) put(s9[i], 1'b0, i == 8);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"},    bus.tx_valid,    0);
        chk({tag, "_sop"},      bus.tx_sop,      0);
        chk({tag, "_eop"},      bus.tx_eop,      0);
        chk({tag, "_data"},     bus.tx_data,     0);
        chk({tag, "_lt_ready"}, bus.tx_lt_ready, 0);
        chk({tag, "_sop_en"},   tx_sop_en,       0);
        chk({tag, "_eop_en"},   tx_eop_en,       0);
    endtask

    // Downstream ready / upstream enable randomisation.
    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.tx_ready = rdy_mode ? 1'b1 : 1'($urandom_range(0, 1));
            if (on_rand) tx_data_on = ($urandom_range(0, 4) != 0);
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic       prev_stall = 1'b0;
        logic [7:0] pd;
        logic       ps, pe;
        exp_t       x;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", bus.tx_valid, 1);
                    chk("stall_data",  bus.tx_data,  pd);
                    chk("stall_sop",   bus.tx_sop,   ps);
                    chk("stall_eop",   bus.tx_eop,   pe);
                end
                if (tx_sop_en) sop_seen++;
                if (tx_eop_en) eop_seen++;
                if (bus.tx_valid && bus.tx_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_byte: got %0h with nothing expected", bus.tx_data);
                    end else begin
                        x = exp_q.pop_front();
                        chk("out_data", bus.tx_data, x.d);
                        chk("out_sop",  bus.tx_sop,  x.sop);
                        chk("out_eop",  bus.tx_eop,  x.eop);
                    end
                end
                prev_stall = bus.tx_valid && !bus.tx_ready;
                pd = bus.tx_data; ps = bus.tx_sop; pe = bus.tx_eop;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bus.tx_lt_valid = 1'b1;
        bus.tx_lt_sop   = 1'b1;
        bus.tx_lt_eop   = 1'b0;
        bus.tx_lt_data  = 8'hC3;
        tx_data_on      = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        bus.tx_lt_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Normal packet, zero-length packet, then backpressure
        put_normal();
        put(8'h4B, 1'b1, 1'b1);
        rdy_mode = 1'b0;
        put_normal();
        rdy_mode = 1'b1;

        // Upstream gating mid-payload
        put(8'hC3, 1'b1, 1'b0);
        put(8'h31, 1'b0, 1'b0);
        put(8'h32, 1'b0, 1'b0);
        put(8'h33, 1'b0, 1'b0);
        tx_data_on = 1'b0;
        bus.tx_lt_data = 8'h34; bus.tx_lt_sop = 1'b0; bus.tx_lt_eop = 1'b0;
        bus.tx_lt_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("gated_lt_ready", bus.tx_lt_ready, 0);
        end
        @(posedge clk); #1;
        tx_data_on = 1'b1;
        put(8'h34, 1'b0, 1'b0);
        put(8'h35, 1'b0, 1'b0); put(8'h36, 1'b0, 1'b0);
        put(8'h37, 1'b0, 1'b0); put(8'h38, 1'b0, 1'b0);
        put(8'h39, 1'b0, 1'b1);

        // Stray byte in IDLE, then restart mid-payload
        put(8'h55, 1'b0, 1'b0);
        put_normal();
        put(8'hA5, 1'b1, 1'b0);
        put(8'h11, 1'b0, 1'b0);
        put(8'h22, 1'b0, 1'b0);
        put_normal();

        // Reset after 4 payload bytes
        put(8'hC3, 1'b1, 1'b0);
        put(8'h31, 1'b0, 1'b0); put(8'h32, 1'b0, 1'b0);
        put(8'h33, 1'b0, 1'b0); put(8'h34, 1'b0, 1'b0);
        rst_n = 1'b0;
        foreach (exp_q[k]) if (exp_q[k].eop) exp_eop_cnt--;
        exp_q.delete();
        m_in = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        put_normal();

        // Random packets with random backpressure and enable gaps
        rdy_mode = 1'b0;
        on_rand  = 1'b1;
        for (int p = 0; p < 20; p++) begin
            int len;
            len = $urandom_range(0, 12);
            if ($urandom_range(0, 5) == 0) put(8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
            put(8'($urandom), 1'b1, len == 0);
            for (int j = 0; j < len; j++) put(8'($urandom), 1'b0, j == len - 1);
        end
        on_rand    = 1'b0;
        tx_data_on = 1'b1;
        rdy_mode   = 1'b1;

        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("drain_valid_low",   bus.tx_valid, 0);
        chk("sop_en_count", sop_seen, exp_sop_cnt);
        chk("eop_en_count", eop_seen, exp_eop_cnt);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/crc16_t.md
# crc16_t

Transmit-side DATA-phase CRC16 generator. Accepts a DATA packet (PID byte plus payload) from the transfer layer and computes the USB CRC16 over the payload. It forwards all bytes through one output register stage to the crc5_t/link transmit path and appends the two CRC bytes after the last payload byte. It is the transmit counterpart of crc16_r and reports packet start and end events to link_control.

## Interface
- No parameters.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- tx_data_on  in  1  link_control enable; gates upstream acceptance only
- tx_sop_en  out  1  pulse: PID byte accepted from transfer layer
- tx_eop_en  out  1  pulse: final CRC byte accepted downstream
- tx_lt_sop  in  1  transfer layer: byte is PID (first byte)
- tx_lt_eop  in  1  transfer layer: byte is last of packet
- tx_lt_valid  in  1  transfer layer byte valid
- tx_lt_ready  out  1  block accepts transfer layer byte
- tx_lt_data  in  8  transfer layer byte
- tx_sop  out  1  downstream: byte is PID
- tx_eop  out  1  downstream: byte is last (CRC high byte)
- tx_valid  out  1  downstream byte valid
- tx_ready  in  1  downstream accepts byte
- tx_data  out  8  downstream byte

## Operation
- Handshakes:
  - Upstream transfer: tx_lt_valid && tx_lt_ready.
  - Downstream transfer: tx_valid && tx_ready.
- Output register:
  - Holds tx_data, tx_sop, tx_eop and tx_valid.
  - "Free" = !tx_valid || tx_ready.
  - Loads only when free. When free and nothing is loaded, tx_valid clears.
- State machine: IDLE, DATA, CRC_LO, CRC_HI.
- IDLE:
  - tx_lt_ready = tx_data_on && free.
  - A byte with tx_lt_sop is the PID: forward it with tx_sop=1, set crc=16'hFFFF, pulse tx_sop_en.
  - PID with tx_lt_sop && tx_lt_eop (zero-length packet) → CRC_LO. Otherwise → DATA.
  - A byte without tx_lt_sop is accepted and discarded, nothing forwarded.
- DATA:
  - tx_lt_ready = tx_data_on && free.
  - Each accepted payload byte is forwarded and updates the CRC.
  - Byte with tx_lt_eop → CRC_LO, with CRC updated by that byte.
  - Byte with tx_lt_sop restarts the packet: treated as a new PID, CRC reset, tx_sop_en pulses, stays in DATA.
- CRC_LO:
  - tx_lt_ready=0.
  - When free, load ~crc[7:0] with tx_sop=0, tx_eop=0 → CRC_HI.
- CRC_HI:
  - tx_lt_ready=0.
  - When free, load ~crc[15:8] with tx_eop=1 → IDLE.
- CRC update (reflected CRC-16/USB, poly 0x8005, LSB first):
  - For each bit i=0..7: fb = crc[0]^d[i]; crc = crc>>1; if fb, crc ^= 16'hA001.
  - All 8 bits are applied combinationally within one cycle.
- The PID is never included in the CRC.
- tx_eop_en = tx_valid && tx_ready && tx_eop (combinational pulse).
- tx_data_on low:
  - Stalls upstream acceptance only; state is kept.
  - Already-loaded output data and pending CRC bytes still drain.

## Timing
- Reset values: tx_valid=0, tx_sop=0, tx_eop=0, tx_data=8'h00, state=IDLE, crc=16'hFFFF, tx_lt_ready=0.
- tx_sop_en and tx_eop_en are 0 in reset.
- Latency: a byte accepted at edge N is on tx_data from edge N through the following cycle (1-cycle register latency).
- Throughput: 1 byte/clk when tx_ready is held high.
- Downstream stall: with tx_ready=0 and tx_valid=1, tx_lt_ready=0 and the output register holds stable.
- tx_lt_ready depends combinationally on tx_ready and state. No combinational path from tx_lt_valid to tx_valid.
- Packet length: n payload bytes occupy n+1 upstream transfers plus 2 CRC load cycles. tx_lt_ready is low for exactly 2 cycles after the eop byte when tx_ready stays high.
- The next PID can be accepted in the cycle after the CRC_HI load.
- Reset mid-packet: immediate return to reset values; no partial CRC is emitted after release.

## Test plan
- Normal packet:
  - Stimulus: PID C3 (sop), then 31 32 33 34 35 36 37 38 39 ("123456789", eop on 39), tx_ready=1.
  - Required: downstream C3 31..39 C8 B4; tx_sop only on C3, tx_eop only on B4; tx_sop_en once, tx_eop_en once.
- Zero-length packet:
  - Stimulus: PID 4B with sop+eop.
  - Required: downstream 4B 00 00, tx_eop on the second 00.
- Backpressure:
  - Stimulus: the normal packet with tx_ready toggling pseudo-randomly.
  - Required: identical byte sequence; tx_data/tx_sop/tx_eop stable while tx_valid && !tx_ready; no duplicated or dropped bytes.
- Upstream gating:
  - Stimulus: tx_data_on low during DATA with tx_lt_valid=1.
  - Required: tx_lt_ready=0, nothing accepted; on re-enable the packet resumes with correct CRC C8 B4.
- Stray data and mid-packet restart:
  - Stimulus: byte 55 without sop in IDLE, then the normal packet.
  - Required: 55 discarded; output identical to the normal packet.
  - Stimulus: a sop byte mid-payload.
  - Required: CRC restarts from that PID.
- Reset mid-packet:
  - Stimulus: rst_n low after 4 payload bytes, then the normal packet.
  - Required: all outputs at reset values while low; second packet correct with CRC C8 B4.
